// File: rtl/bram_bit_streamer.sv
// Reads packed words from a synchronous block RAM and plays them out MSB-first,
// one bit per slow strobe, with one-shot or looping playback.
module bram_bit_streamer #(
  parameter int CLK_HZ    = 100000000,
  parameter int TICK_HZ   = 1,
  parameter int WORD_W    = 8,
  parameter int ADDR_W    = 4,
  parameter int NUM_WORDS = 16,
  parameter int RD_LAT    = 1,
  parameter int LOOP      = 0
) (
  input  logic              clock_100Mhz,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_dout,
  output logic              serial_bit,
  output logic              one_second_enable,
  output logic              active,
  output logic              done,
  output logic [15:0]       bits_sent,
  output logic [2:0]        fsm_state
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int DIV_W = $clog2(DIV);
  localparam int BIT_W = ($clog2(WORD_W) > 0) ? $clog2(WORD_W) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(WORD_W - 1);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRIME0 = 3'd1,
    PRIME1 = 3'd2,
    STREAM = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t state;
  state_t state_next;

  logic [DIV_W-1:0]  div;
  logic [BIT_W-1:0]  bit_idx;
  logic [ADDR_W-1:0] word_cnt;
  logic [WORD_W-1:0] shift_reg;
  logic [WORD_W-1:0] next_word;
  logic [RD_LAT:0]   pend;
  logic [ADDR_W-1:0] next_addr;

  logic rd_req;
  logic rd_first;
  logic load_shift;
  logic load_next;
  logic clear_pass;
  logic strobe;
  logic data_ready;
  logic last_bit;

  // RAM contract: a read is issued in the cycle mem_en is high and mem_dout
  // carries that word exactly RD_LAT cycles later; pend tracks that pipeline.
  assign mem_en     = pend[0];
  assign data_ready = pend[RD_LAT];
  assign last_bit   = (bit_idx == LAST_BIT);
  assign next_addr  = (mem_addr == LAST_WORD) ? '0 : mem_addr + ADDR_W'(1);

  assign serial_bit        = (state == STREAM) & shift_reg[WORD_W-1];
  assign one_second_enable = strobe;
  assign active            = (state == PRIME0) | (state == PRIME1) | (state == STREAM);
  assign done              = (state == DONE);
  assign fsm_state         = state;

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    rd_req     = 1'b0;
    rd_first   = 1'b0;
    load_shift = 1'b0;
    load_next  = 1'b0;
    clear_pass = 1'b0;
    strobe     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start && !stop) begin
          state_next = PRIME0;
          rd_req     = 1'b1;
          rd_first   = 1'b1;
          clear_pass = 1'b1;
        end
      end
      PRIME0: begin
        if (stop) begin
          state_next = IDLE;
        end else if (data_ready) begin
          load_shift = 1'b1;
          rd_req     = 1'b1;
          state_next = PRIME1;
        end
      end
      PRIME1: begin
        if (stop) begin
          state_next = IDLE;
        end else if (data_ready) begin
          load_next  = 1'b1;
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (stop) begin
          state_next = IDLE;
        end else begin
          load_next = data_ready;
          if (div == DIV_LAST) begin
            strobe = 1'b1;
            // The final bit of a one-shot pass needs no refill read.
            if (last_bit && (word_cnt == LAST_WORD) && (LOOP == 0)) begin
              state_next = DONE;
            end else if (last_bit) begin
              rd_req = 1'b1;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      pend      <= '0;
      mem_addr  <= '0;
      div       <= '0;
      bit_idx   <= '0;
      word_cnt  <= '0;
      shift_reg <= '0;
      next_word <= '0;
      bits_sent <= '0;
    end else begin
      // Leaving the active states drops any read still in flight.
      if ((state_next == IDLE) || (state_next == DONE)) begin
        pend <= '0;
      end else begin
        pend <= {pend[RD_LAT-1:0], rd_req};
      end

      if (rd_req) begin
        mem_addr <= rd_first ? '0 : next_addr;
      end

      if (state != STREAM) begin
        div <= '0;
      end else if (div == DIV_LAST) begin
        div <= '0;
      end else begin
        div <= div + DIV_W'(1);
      end

      if (load_shift) begin
        shift_reg <= mem_dout;
        bit_idx   <= '0;
        word_cnt  <= '0;
      end else if (strobe) begin
        if (last_bit) begin
          shift_reg <= next_word;
          bit_idx   <= '0;
          word_cnt  <= (word_cnt == LAST_WORD) ? '0 : word_cnt + ADDR_W'(1);
        end else begin
          shift_reg <= {shift_reg[WORD_W-2:0], 1'b0};
          bit_idx   <= bit_idx + BIT_W'(1);
        end
      end

      if (load_next) begin
        next_word <= mem_dout;
      end

      if (clear_pass) begin
        bits_sent <= '0;
      end else if (strobe && (bits_sent != 16'hFFFF)) begin
        bits_sent <= bits_sent + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_bram_bit_streamer.sv
// Directed bench: three streamer instances (one-shot, looping, slow RAM at
// minimum divider) each fed by a small synchronous RAM model.
module tb_bram_bit_streamer;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  // Instance A: one-shot, RD_LAT=1, RAM {B0,0F}
  logic        start_a = 1'b0, stop_a = 1'b0;
  logic        mem_en_a, bit_a, ose_a, active_a, done_a;
  logic [3:0]  addr_a;
  logic [7:0]  dout_a;
  logic [15:0] sent_a;
  logic [2:0]  st_a;
  logic [7:0]  ram_a [16];

  // Instance B: looping, same RAM contents
  logic        start_b = 1'b0, stop_b = 1'b0;
  logic        mem_en_b, bit_b, ose_b, active_b, done_b;
  logic [3:0]  addr_b;
  logic [7:0]  dout_b;
  logic [15:0] sent_b;
  logic [2:0]  st_b;
  logic [7:0]  ram_b [16];

  // Instance C: RD_LAT=2, DIV=5, RAM {FF,00}
  logic        start_c = 1'b0, stop_c = 1'b0;
  logic        mem_en_c, bit_c, ose_c, active_c, done_c;
  logic [3:0]  addr_c;
  logic [7:0]  dout_c, stage_c;
  logic [15:0] sent_c;
  logic [2:0]  st_c;
  logic [7:0]  ram_c [16];

  always @(posedge clk) if (mem_en_a) dout_a <= ram_a[addr_a];
  always @(posedge clk) if (mem_en_b) dout_b <= ram_b[addr_b];
  always @(posedge clk) begin
    if (mem_en_c) stage_c <= ram_c[addr_c];
    dout_c <= stage_c;
  end

  bram_bit_streamer #(.CLK_HZ(10), .TICK_HZ(1), .WORD_W(8), .ADDR_W(4),
                      .NUM_WORDS(2), .RD_LAT(1), .LOOP(0)) dut_a (
    .clock_100Mhz(clk), .reset(reset), .start(start_a), .stop(stop_a),
    .mem_en(mem_en_a), .mem_addr(addr_a), .mem_dout(dout_a),
    .serial_bit(bit_a), .one_second_enable(ose_a), .active(active_a),
    .done(done_a), .bits_sent(sent_a), .fsm_state(st_a)
  );

  bram_bit_streamer #(.CLK_HZ(10), .TICK_HZ(1), .WORD_W(8), .ADDR_W(4),
                      .NUM_WORDS(2), .RD_LAT(1), .LOOP(1)) dut_b (
    .clock_100Mhz(clk), .reset(reset), .start(start_b), .stop(stop_b),
    .mem_en(mem_en_b), .mem_addr(addr_b), .mem_dout(dout_b),
    .serial_bit(bit_b), .one_second_enable(ose_b), .active(active_b),
    .done(done_b), .bits_sent(sent_b), .fsm_state(st_b)
  );

  bram_bit_streamer #(.CLK_HZ(5), .TICK_HZ(1), .WORD_W(8), .ADDR_W(4),
                      .NUM_WORDS(2), .RD_LAT(2), .LOOP(0)) dut_c (
    .clock_100Mhz(clk), .reset(reset), .start(start_c), .stop(stop_c),
    .mem_en(mem_en_c), .mem_addr(addr_c), .mem_dout(dout_c),
    .serial_bit(bit_c), .one_second_enable(ose_c), .active(active_c),
    .done(done_c), .bits_sent(sent_c), .fsm_state(st_c)
  );

  // Strobe capture: bit value and cycle number of every strobe
  logic obs_a[$], obs_b[$], obs_c[$];
  int   tcy_a[$], tcy_b[$], tcy_c[$];
  logic done_seen_b = 1'b0;

  always @(negedge clk) begin
    if (ose_a) begin obs_a.push_back(bit_a); tcy_a.push_back(cyc); end
    if (ose_b) begin obs_b.push_back(bit_b); tcy_b.push_back(cyc); end
    if (ose_c) begin obs_c.push_back(bit_c); tcy_c.push_back(cyc); end
    if (done_b) done_seen_b = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int nstb(input int which);
    case (which)
      0: return obs_a.size();
      1: return obs_b.size();
      default: return obs_c.size();
    endcase
  endfunction

  function automatic logic obs_bit(input int which, input int i);
    case (which)
      0: return obs_a[i];
      1: return obs_b[i];
      default: return obs_c[i];
    endcase
  endfunction

  function automatic int obs_cyc(input int which, input int i);
    case (which)
      0: return tcy_a[i];
      1: return tcy_b[i];
      default: return tcy_c[i];
    endcase
  endfunction

  task automatic clear_obs();
    obs_a.delete(); obs_b.delete(); obs_c.delete();
    tcy_a.delete(); tcy_b.delete(); tcy_c.delete();
  endtask

  task automatic pulse(input int which, input logic s, input logic p);
    @(posedge clk); #1;
    case (which)
      0: begin start_a = s; stop_a = p; end
      1: begin start_b = s; stop_b = p; end
      default: begin start_c = s; stop_c = p; end
    endcase
    @(posedge clk); #1;
    start_a = 1'b0; stop_a = 1'b0;
    start_b = 1'b0; stop_b = 1'b0;
    start_c = 1'b0; stop_c = 1'b0;
  endtask

  task automatic wait_strobes(input int which, input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (nstb(which) < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    check(tag, nstb(which), n);
  endtask

  task automatic check_stream(input int which, input logic [15:0] pat, input int n,
                              input int period, input string tag);
    logic [0:0] exp_q[$];
    logic [0:0] e;
    for (int i = 0; i < n; i++) exp_q.push_back(pat[15 - (i % 16)]);
    check($sformatf("%s_count", tag), nstb(which), n);
    for (int i = 0; i < n && i < nstb(which); i++) begin
      e = exp_q.pop_front();
      check($sformatf("%s_bit%0d", tag, i), obs_bit(which, i), e);
      if (i > 0) check($sformatf("%s_gap%0d", tag, i), obs_cyc(which, i) - obs_cyc(which, i - 1), period);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      ram_a[i] = 8'h00; ram_b[i] = 8'h00; ram_c[i] = 8'h00;
    end
    ram_a[0] = 8'hB0; ram_a[1] = 8'h0F;
    ram_b[0] = 8'hB0; ram_b[1] = 8'h0F;
    ram_c[0] = 8'hFF; ram_c[1] = 8'h00;

    // Reset state
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_active", active_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_bit", bit_a, 1'b0);
    check("rst_ose", ose_a, 1'b0);
    check("rst_sent", sent_a, 16'd0);
    check("rst_mem_en", mem_en_a, 1'b0);
    check("rst_addr", addr_a, 4'd0);
    check("rst_state", st_a, 3'd0);
    @(posedge clk); #1 reset = 1'b0;

    // start together with stop in IDLE: stop wins
    pulse(0, 1'b1, 1'b1);
    @(negedge clk); #1;
    check("ss_active", active_a, 1'b0);
    check("ss_state", st_a, 3'd0);
    repeat (20) @(negedge clk);
    check("ss_no_strobe", nstb(0), 0);

    // One-shot pass with a redundant start mid-stream
    clear_obs();
    pulse(0, 1'b1, 1'b0);
    wait_strobes(0, 3, 200, "a_wait3");
    pulse(0, 1'b1, 1'b0);
    wait_strobes(0, 16, 400, "a_wait16");
    check("a_done_at_strobe", done_a, 1'b0);
    @(negedge clk); #1;
    check("a_done", done_a, 1'b1);
    check("a_active", active_a, 1'b0);
    check("a_sent", sent_a, 16'd16);
    check("a_bit_low", bit_a, 1'b0);
    repeat (30) @(negedge clk);
    check_stream(0, 16'hB00F, 16, 10, "a_oneshot");

    // Stop coinciding with the strobe of bit 5, then restart from DONE/IDLE
    clear_obs();
    pulse(0, 1'b1, 1'b0);
    wait_strobes(0, 5, 200, "stop_wait5");
    repeat (10) @(posedge clk);
    #1 stop_a = 1'b1;
    @(negedge clk); #1;
    check("stop_strobe_suppressed", ose_a, 1'b0);
    @(posedge clk); #1 stop_a = 1'b0;
    @(negedge clk);
    check("stop_active", active_a, 1'b0);
    check("stop_done", done_a, 1'b0);
    check("stop_state", st_a, 3'd0);
    check("stop_sent", sent_a, 16'd5);
    repeat (30) @(negedge clk);
    check("stop_no_more", nstb(0), 5);
    clear_obs();
    pulse(0, 1'b1, 1'b0);
    wait_strobes(0, 16, 400, "restart_wait16");
    check_stream(0, 16'hB00F, 16, 10, "restart");

    // Looping playback across the word 1 -> 0 wrap
    clear_obs();
    done_seen_b = 1'b0;
    pulse(1, 1'b1, 1'b0);
    wait_strobes(1, 40, 600, "loop_wait40");
    pulse(1, 1'b0, 1'b1);
    @(negedge clk); #1;
    check("loop_active_after_stop", active_b, 1'b0);
    check("loop_done_never", done_seen_b, 1'b0);
    check("loop_sent", sent_b, 16'd40);
    check_stream(1, 16'hB00F, 40, 10, "loop");

    // Two-cycle RAM with the minimum divider
    clear_obs();
    pulse(2, 1'b1, 1'b0);
    wait_strobes(2, 16, 300, "slow_wait16");
    @(negedge clk); #1;
    check("slow_done", done_c, 1'b1);
    check("slow_sent", sent_c, 16'd16);
    check_stream(2, 16'hFF00, 16, 5, "slow");

    // Reset asserted mid-stream
    clear_obs();
    pulse(0, 1'b1, 1'b0);
    wait_strobes(0, 3, 200, "mid_wait3");
    #3 reset = 1'b1;
    #1;
    check("mid_rst_active", active_a, 1'b0);
    check("mid_rst_sent", sent_a, 16'd0);
    check("mid_rst_addr", addr_a, 4'd0);
    check("mid_rst_mem_en", mem_en_a, 1'b0);
    check("mid_rst_ose", ose_a, 1'b0);
    check("mid_rst_bit", bit_a, 1'b0);
    check("mid_rst_done", done_a, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    clear_obs();
    repeat (100) @(negedge clk);
    check("post_rst_no_strobe", nstb(0), 0);
    check("post_rst_active", active_a, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_bit_streamer.md
Name: bram_bit_streamer

Overview:
- Upstream feeder for the pattern-detection stage.
- Reads packed words from a synchronous Block RAM and serialises them MSB-first onto a single-bit output.
- Generates the slow `one_second_enable` strobe; each bit is valid and stable in the strobe cycle.
- Supports one-shot or looping playback, start/stop control and a done flag.

Parameters:
- CLK_HZ, 100000000, input clock frequency.
- TICK_HZ, 1, strobe rate. DIV = CLK_HZ/TICK_HZ clock cycles per bit; DIV must be >= RD_LAT+3.
- WORD_W, 8, RAM data width (bits per word).
- ADDR_W, 4, RAM address width.
- NUM_WORDS, 16, words streamed per pass (<= 2^ADDR_W).
- RD_LAT, 1, RAM read latency in cycles (1 or 2).
- LOOP, 0, 1 = wrap to word 0 after the last word; 0 = stop and flag done.

Ports:
- clock_100Mhz  in   1  system clock
- reset  in  1  asynchronous, active-high
- start  in  1  single-cycle pulse; begins a pass from word 0 when idle or done
- stop  in  1  single-cycle pulse; aborts streaming
- mem_en  out  1  RAM read enable
- mem_addr  out  ADDR_W  RAM read address
- mem_dout  in  WORD_W  RAM read data, valid RD_LAT cycles after mem_en
- bit  out  1  serial data bit (MSB of current word first)
- one_second_enable  out  1  one-cycle strobe; bit is valid in this cycle
- active  out  1  high while priming or streaming
- done  out  1  high after a completed one-shot pass, until next start or reset
- bits_sent  out  16  count of strobes issued in the current pass

Behaviour:
- Reset: clock_100Mhz, reset asynchronous, active-high.
  - All outputs go to 0.
  - FSM goes to IDLE; divider, bit index and address are cleared.
- FSM states: IDLE, PRIME0, PRIME1, STREAM, DONE.
- IDLE/DONE:
  - start=1 and stop=0 -> PRIME0, with active=1, bits_sent=0 and done cleared.
  - start together with stop -> stay in the current state (stop wins).
- PRIME0:
  - Issue read of addr 0, wait RD_LAT cycles, load `mem_dout` into the shift register.
  - Then PRIME1: read the next address into the next_word buffer.
  - Enter STREAM with the divider at 0.
- STREAM divider:
  - Counts 0..DIV-1.
  - When it reaches DIV-1, `one_second_enable`=1 for exactly one cycle.
  - `bit` = `shift_reg[WORD_W-1]` continuously, including the strobe cycle.
- STREAM per strobe:
  - bits_sent increments (saturates at 0xFFFF); bit index increments.
  - Not last bit of word -> shift left by 1 on the cycle after the strobe.
  - Last bit -> shift_reg <= next_word and bit index <= 0.
- STREAM word advance:
  - The last-bit strobe triggers a read of the following address (mod NUM_WORDS) into next_word.
  - The read completes well before the next strobe, guaranteed by the DIV constraint.
- First strobe occurs DIV cycles after entering STREAM; strobes are then exactly DIV cycles apart, with no jitter at word boundaries.
- End of pass (strobe on last bit of word NUM_WORDS-1):
  - LOOP=1 -> continue seamlessly with word 0; next_word was already prefetched from address 0.
  - LOOP=0 -> go to DONE in the next cycle; active=0, done=1, bit=0, no further strobes.
- stop in any non-IDLE state:
  - Next state IDLE; active=0, done stays 0.
  - If stop coincides with the divider reaching DIV-1, the strobe is suppressed.
  - Any outstanding RAM read is discarded.
- start while active: ignored.
- mem_en is high only in cycles issuing a read; mem_addr holds its last value otherwise.
- Reset mid-stream: immediate return to the reset state; no strobe is emitted that cycle.

Test Plan:
- CLK_HZ=10, TICK_HZ=1 (DIV=10), WORD_W=8, NUM_WORDS=2, RAM={B0,0F}, LOOP=0, pulse start:
  - 16 strobes exactly 10 cycles apart.
  - bit sequence 1011000000001111.
  - After the 16th strobe: done=1, active=0, bits_sent=16.
- Same setup with LOOP=1, run 40 strobes:
  - bit sequence repeats with period 16; strobe spacing stays 10 across the word 1->0 wrap.
  - done never asserts.
- RD_LAT=2, RAM={FF,00}, DIV=5 (minimum):
  - bits 8x1 then 8x0.
  - No strobe spacing deviation at the word boundary.
- Pulse stop in the same cycle the divider hits 9 during bit 5:
  - No strobe that cycle; active=0, done=0 next cycle.
  - A subsequent start restarts from word 0 bit 0.
- Assert reset mid-stream:
  - All outputs 0 asynchronously.
  - After release, with no start, no strobes occur for 100 cycles.
- Simultaneous start+stop in IDLE -> stays IDLE, active=0. start pulse while streaming -> bit sequence unchanged.
